// File: rtl/aes_blk_feeder_pkg.sv
// rtl/aes_blk_feeder_pkg.sv - shared AES types, feeder entry struct and key masking
package aes_blk_feeder_pkg;

    typedef logic [127:0] aes_128;
    typedef logic [255:0] key_256;

    typedef enum logic [1:0] {
        NOOP    = 2'd0,
        ENC_128 = 2'd1,
        ENC_192 = 2'd2,
        ENC_256 = 2'd3
    } mode;

    typedef enum logic {
        PK_IDLE = 1'b0,
        PK_FILL = 1'b1
    } pk_state;

    typedef struct packed {
        aes_128     data;
        key_256     key;
        mode        m;
        logic [1:0] pad;
    } feeder_entry;

    localparam int FIFO_DEPTH = 2;

    // Keys are MSB-aligned; bits below the key length are forced to zero so the
    // core never sees stale configuration bits. NOOP carries no key at all.
    function automatic key_256 key_mask(input mode m, input key_256 k);
        key_256 r;
        r = k;
        case (m)
            ENC_128: r[127:0] = '0;
            ENC_192: r[63:0]  = '0;
            ENC_256: r        = k;
            default: r        = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/aes_blk_feeder_fifo.sv
// rtl/aes_blk_feeder_fifo.sv - 2-entry block buffer whose head slot is the staged block
module aes_blk_fifo
    import aes_blk_feeder_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  feeder_entry push_entry,
    input  logic        pop,
    output feeder_entry head,
    output logic [1:0]  count
);

    feeder_entry slot0;
    feeder_entry slot1;
    logic [1:0]  cnt;
    logic        do_pop;
    logic        do_push;

    // Pop on an empty buffer is a no-op; push into a full buffer is only allowed
    // alongside a pop that frees the head.
    assign do_pop  = pop && (cnt != 2'd0);
    assign do_push = push && ((cnt != 2'(FIFO_DEPTH)) || do_pop);

    // Shift-style storage: slot0 is always the head, and any slot not holding a
    // live entry is kept at zero so the head reads as all-zero/NOOP when empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot0 <= '0;
            slot1 <= '0;
            cnt   <= 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (cnt == 2'd0) begin
                        slot0 <= push_entry;
                    end else begin
                        slot1 <= push_entry;
                    end
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    slot0 <= slot1;
                    slot1 <= '0;
                    cnt   <= cnt - 2'd1;
                end
                2'b11: begin
                    if (cnt == 2'd1) begin
                        slot0 <= push_entry;
                    end else begin
                        slot0 <= slot1;
                        slot1 <= push_entry;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign head  = slot0;
    assign count = cnt;

endmodule

// File: rtl/aes_blk_feeder.sv
// rtl/aes_blk_feeder.sv - packs 32-bit words into 128-bit AES blocks and stages them for the core
module aes_blk_feeder
    import aes_blk_feeder_pkg::*;
#(
    parameter int CNT_W = 32
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_load_i,
    input  key_256           cfg_key_i,
    input  mode              cfg_mode_i,
    output logic             cfg_ready_o,
    input  logic [31:0]      s_data_i,
    input  logic             s_valid_i,
    input  logic             s_last_i,
    output logic             s_ready_o,
    output aes_128           blk_data_o,
    output key_256           blk_key_o,
    output mode              blk_mode_o,
    input  logic             core_ready_i,
    output logic [1:0]       pad_o,
    output logic [CNT_W-1:0] blk_cnt_o
);

    pk_state     state;
    logic [1:0]  idx;
    aes_128      fill;
    mode         cfg_mode;
    key_256      cfg_key;
    logic [1:0]  buf_count;
    feeder_entry head;
    feeder_entry new_entry;
    aes_128      lane_word;
    logic        accept;
    logic        closing;
    logic        retire;

    assign s_ready_o   = (cfg_mode != NOOP) && (buf_count < 2'(FIFO_DEPTH));
    assign cfg_ready_o = (state == PK_IDLE) && (buf_count == 2'd0);
    assign accept      = s_valid_i && s_ready_o;
    assign closing     = accept && ((idx == 2'd3) || s_last_i);
    assign retire      = core_ready_i && (buf_count != 2'd0);

    // Place the incoming word in its lane; word 0 is the most significant lane.
    always_comb begin
        lane_word = '0;
        case (idx)
            2'd0: lane_word[127:96] = s_data_i;
            2'd1: lane_word[95:64]  = s_data_i;
            2'd2: lane_word[63:32]  = s_data_i;
            default: lane_word[31:0] = s_data_i;
        endcase
    end

    // The closing word is merged straight into the pushed entry; lanes after it
    // stay zero because the fill register is cleared on every close.
    always_comb begin
        new_entry      = '0;
        new_entry.data = fill | lane_word;
        new_entry.key  = cfg_key;
        new_entry.m    = cfg_mode;
        new_entry.pad  = 2'd3 - idx;
    end

    // Packer state machine plus the configuration registers it guards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= PK_IDLE;
            idx      <= 2'd0;
            fill     <= '0;
            cfg_mode <= NOOP;
            cfg_key  <= '0;
        end else begin
            if (cfg_load_i && cfg_ready_o) begin
                cfg_mode <= cfg_mode_i;
                cfg_key  <= key_mask(cfg_mode_i, cfg_key_i);
            end
            if (accept) begin
                if (closing) begin
                    state <= PK_IDLE;
                    idx   <= 2'd0;
                    fill  <= '0;
                end else begin
                    state <= PK_FILL;
                    idx   <= idx + 2'd1;
                    fill  <= fill | lane_word;
                end
            end
        end
    end

    // Count every block the core takes from the head of the buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_cnt_o <= '0;
        end else if (retire) begin
            blk_cnt_o <= blk_cnt_o + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    aes_blk_fifo u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (closing),
        .push_entry (new_entry),
        .pop        (core_ready_i),
        .head       (head),
        .count      (buf_count)
    );

    assign blk_data_o = head.data;
    assign blk_key_o  = head.key;
    assign blk_mode_o = head.m;
    assign pad_o      = head.pad;

endmodule

// File: tb/tb_aes_blk_feeder.sv
// tb/tb_aes_blk_feeder.sv - self-checking bench for aes_blk_feeder
module tb_aes_blk_feeder;
    import aes_blk_feeder_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_load = 1'b0;
    key_256      cfg_key = '0;
    mode         cfg_mode = NOOP;
    logic [31:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        core_ready = 1'b0;

    logic        cfg_ready, s_ready;
    aes_128      blk_data;
    key_256      blk_key;
    mode         blk_mode;
    logic [1:0]  pad;
    logic [31:0] blk_cnt;

    logic        cfg_ready4, s_ready4;
    aes_128      blk_data4;
    key_256      blk_key4;
    mode         blk_mode4;
    logic [1:0]  pad4;
    logic [3:0]  blk_cnt4;

    int n_checks = 0;
    int n_pass   = 0;

    localparam key_256 K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam key_256 K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    always #5 clk = ~clk;

    aes_blk_feeder #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .cfg_load_i(cfg_load), .cfg_key_i(cfg_key),
        .cfg_mode_i(cfg_mode), .cfg_ready_o(cfg_ready), .s_data_i(s_data),
        .s_valid_i(s_valid), .s_last_i(s_last), .s_ready_o(s_ready),
        .blk_data_o(blk_data), .blk_key_o(blk_key), .blk_mode_o(blk_mode),
        .core_ready_i(core_ready), .pad_o(pad), .blk_cnt_o(blk_cnt)
    );

    aes_blk_feeder #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .cfg_load_i(cfg_load), .cfg_key_i(cfg_key),
        .cfg_mode_i(cfg_mode), .cfg_ready_o(cfg_ready4), .s_data_i(s_data),
        .s_valid_i(s_valid), .s_last_i(s_last), .s_ready_o(s_ready4),
        .blk_data_o(blk_data4), .blk_key_o(blk_key4), .blk_mode_o(blk_mode4),
        .core_ready_i(core_ready), .pad_o(pad4), .blk_cnt_o(blk_cnt4)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic fail_timeout(input string name);
        n_checks++;
        $display("FAIL %s: got timeout expected handshake", name);
    endtask

    // Behavioural model: key masks by slicing, block is a queue of words
    function automatic key_256 model_mask(input mode mm, input key_256 k);
        case (mm)
            ENC_128: return {k[255:128], 128'b0};
            ENC_192: return {k[255:64], 64'b0};
            ENC_256: return k;
            default: return '0;
        endcase
    endfunction

    mode         m_mode = NOOP;
    key_256      m_key = '0;
    logic [31:0] m_words[4];
    int          m_idx = 0;
    feeder_entry m_q[$];
    int unsigned m_cnt = 0;
    feeder_entry m_e;
    bit          m_acc, m_close, m_pop, m_cfgr;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = NOOP; m_key = '0; m_idx = 0; m_q.delete(); m_cnt = 0;
        end else begin
            m_acc   = s_valid && (m_mode != NOOP) && (m_q.size() < 2);
            m_cfgr  = (m_idx == 0) && (m_q.size() == 0);
            m_pop   = core_ready && (m_q.size() > 0);
            m_close = 1'b0;
            if (m_acc) begin
                m_words[m_idx] = s_data;
                if (m_idx == 3 || s_last) begin
                    m_close = 1'b1;
                    m_e = '0;
                    for (int i = 0; i <= m_idx; i++) m_e.data[127-32*i -: 32] = m_words[i];
                    m_e.key = m_key;
                    m_e.m   = m_mode;
                    m_e.pad = 2'(3 - m_idx);
                    m_idx = 0;
                end else begin
                    m_idx++;
                end
            end
            if (m_pop) begin
                void'(m_q.pop_front());
                m_cnt++;
            end
            if (m_close) m_q.push_back(m_e);
            if (cfg_load && m_cfgr) begin
                m_mode = cfg_mode;
                m_key  = model_mask(cfg_mode, cfg_key);
            end
        end
    end

    // Compare both instances against the model every cycle
    always @(negedge clk) begin
        feeder_entry h;
        h = (m_q.size() > 0) ? m_q[0] : '0;
        check("s_ready", s_ready, (m_mode != NOOP) && (m_q.size() < 2));
        check("cfg_ready", cfg_ready, (m_idx == 0) && (m_q.size() == 0));
        check("blk_data", blk_data, h.data);
        check("blk_key", blk_key, h.key);
        check("blk_mode", blk_mode, h.m);
        check("pad", pad, h.pad);
        check("blk_cnt", blk_cnt, m_cnt);
        check("blk_data4", blk_data4, h.data);
        check("blk_cnt4", blk_cnt4, m_cnt % 16);
    end

    task automatic send(input logic [31:0] d, input logic last);
        bit done;
        done = 1'b0;
        s_valid = 1'b1; s_data = d; s_last = last;
        for (int k = 0; k < 40 && !done; k++) begin
            if (s_ready) done = 1'b1;
            @(posedge clk); #1;
        end
        s_valid = 1'b0; s_last = 1'b0;
        if (!done) fail_timeout("send");
    endtask

    task automatic load(input mode mm, input key_256 k);
        cfg_load = 1'b1; cfg_mode = mm; cfg_key = k;
        @(posedge clk); #1;
        cfg_load = 1'b0;
    endtask

    task automatic retire_all();
        bit done;
        done = 1'b0;
        core_ready = 1'b1;
        for (int k = 0; k < 20 && !done; k++) begin
            @(posedge clk); #1;
            if (blk_mode == NOOP) done = 1'b1;
        end
        core_ready = 1'b0;
        if (!done) fail_timeout("retire_all");
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_cfg_ready", cfg_ready, 1'b1);
        check("rst_s_ready", s_ready, 1'b0);
        check("rst_mode", blk_mode, NOOP);
        check("rst_cnt", blk_cnt, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // FIPS-197 style block with ENC_128
        load(ENC_128, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hdeadbeef_01234567_89abcdef_cafef00d});
        send(32'h3243f6a8, 1'b0);
        send(32'h885a308d, 1'b0);
        send(32'h313198a2, 1'b0);
        send(32'he0370734, 1'b0);
        check("t1_data", blk_data, 128'h3243f6a8885a308d313198a2e0370734);
        check("t1_key", blk_key, K128);
        check("t1_mode", blk_mode, ENC_128);
        check("t1_pad", pad, 2'd0);

        // Backpressure: two blocks fill the buffer
        send(32'h11111111, 1'b0);
        send(32'h22222222, 1'b0);
        send(32'h33333333, 1'b0);
        send(32'h44444444, 1'b0);
        check("t2_s_ready_low", s_ready, 1'b0);
        s_valid = 1'b1; s_data = 32'h55555555;
        repeat (2) @(posedge clk);
        #1;
        check("t2_cnt0", blk_cnt, 32'd0);
        core_ready = 1'b1;
        @(posedge clk); #1;
        core_ready = 1'b0;
        check("t2_cnt1", blk_cnt, 32'd1);
        check("t2_data2", blk_data, 128'h11111111222222223333333344444444);
        check("t2_s_ready_high", s_ready, 1'b1);
        send(32'h55555555, 1'b0);
        send(32'h66666666, 1'b0);
        send(32'h77777777, 1'b0);
        send(32'h88888888, 1'b0);
        retire_all();

        // ENC_192 masks the low 64 bits
        load(ENC_192, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'hffffffffffffffff});
        send(32'ha5a5a5a5, 1'b1);
        check("t3_key192", blk_key, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0});
        check("t3_mode", blk_mode, ENC_192);
        retire_all();

        // ENC_256 keeps the full key; single-word message pads 3
        load(ENC_256, K256);
        send(32'h00112233, 1'b1);
        check("t4_key256", blk_key, K256);
        check("t4_data", blk_data, 128'h00112233_00000000_00000000_00000000);
        check("t4_pad", pad, 2'd3);

        // Push and retire on the same edge with one block buffered
        send(32'haaaa0001, 1'b0);
        send(32'haaaa0002, 1'b0);
        send(32'haaaa0003, 1'b0);
        s_valid = 1'b1; s_data = 32'haaaa0004; core_ready = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b0; core_ready = 1'b0;
        check("t5_data", blk_data, 128'haaaa0001aaaa0002aaaa0003aaaa0004);
        check("t5_cnt", blk_cnt, 32'd5);
        check("t5_cfg_ready", cfg_ready, 1'b0);
        load(ENC_128, '0);
        retire_all();
        check("t5_cnt_drained", blk_cnt, 32'd6);
        send(32'h12345678, 1'b1);
        check("t5_cfg_ignored_mode", blk_mode, ENC_256);
        check("t5_cfg_ignored_key", blk_key, K256);

        // Reset mid-block
        send(32'hbbbb0001, 1'b0);
        send(32'hbbbb0002, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("t6_mode", blk_mode, NOOP);
        check("t6_data", blk_data, 128'h0);
        check("t6_cnt", blk_cnt, 32'd0);
        check("t6_cfg_ready", cfg_ready, 1'b1);
        check("t6_s_ready", s_ready, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Counter wrap on the 4-bit instance
        load(ENC_128, K128);
        core_ready = 1'b1;
        for (int b = 0; b < 15; b++) send(32'hc0de0000 + b, 1'b1);
        @(posedge clk); #1;
        check("t7_cnt4_ff", blk_cnt4, 4'hf);
        check("t7_cnt15", blk_cnt, 32'd15);
        send(32'hc0de00ff, 1'b1);
        @(posedge clk); #1;
        core_ready = 1'b0;
        check("t7_cnt4_wrap", blk_cnt4, 4'h0);
        check("t7_cnt16", blk_cnt, 32'd16);

        // Loading NOOP disables input
        load(NOOP, K256);
        check("t8_noop_s_ready", s_ready, 1'b0);
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
